// File: rtl/mic_array_frame_buffer.sv
// Ping-pong frame buffer: one bank fills from a channel-interleaved sample stream
// while the host reads the other bank.
module mic_array_frame_buffer #(
   parameter int NUM_CHANNELS     = 8,
   parameter int DATA_WIDTH       = 16,
   parameter int FRAME_ADDR_WIDTH = 7,
   localparam int CH_ADDR_WIDTH   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    enable,
   input  logic                                    wr_valid,
   input  logic [DATA_WIDTH-1:0]                   wr_data,
   input  logic                                    rd_en,
   input  logic [CH_ADDR_WIDTH+FRAME_ADDR_WIDTH-1:0] rd_adr,
   output logic [DATA_WIDTH-1:0]                   rd_data,
   input  logic                                    frame_ack,
   output logic                                    frame_ready,
   output logic                                    frame_irq,
   output logic                                    rd_bank,
   output logic [7:0]                              overflow_count
);

   localparam int RAM_AW = 1 + CH_ADDR_WIDTH + FRAME_ADDR_WIDTH;
   localparam logic [CH_ADDR_WIDTH-1:0]    LAST_CH   = CH_ADDR_WIDTH'(NUM_CHANNELS - 1);
   localparam logic [FRAME_ADDR_WIDTH-1:0] LAST_SAMP = '1;

   logic [DATA_WIDTH-1:0] mem [0:(2**RAM_AW)-1];
   logic [DATA_WIDTH-1:0] ram_q;

   logic [CH_ADDR_WIDTH-1:0]    ch_cnt_q, ch_cnt_d;
   logic [FRAME_ADDR_WIDTH-1:0] samp_cnt_q, samp_cnt_d;
   logic                        wr_bank_q, wr_bank_d;
   logic                        frame_ready_q, frame_ready_d;
   logic                        frame_irq_q, frame_irq_d;
   logic [7:0]                  overflow_q, overflow_d;
   logic                        rd_en_q, rd_en_d;

   logic wr_fire;
   logic frame_done;
   logic accept;
   logic discard;

   assign wr_fire    = enable & wr_valid;
   assign frame_done = wr_fire && (ch_cnt_q == LAST_CH) && (samp_cnt_q == LAST_SAMP);
   assign accept     = frame_done & (~frame_ready_q | frame_ack);
   assign discard    = frame_done & frame_ready_q & ~frame_ack;

   always_comb begin
      ch_cnt_d      = ch_cnt_q;
      samp_cnt_d    = samp_cnt_q;
      wr_bank_d     = wr_bank_q;
      frame_ready_d = frame_ready_q;
      frame_irq_d   = 1'b0;
      overflow_d    = overflow_q;
      rd_en_d       = rd_en;

      // Counters wrap on their own at frame end: both are at their last value.
      if (!enable) begin
         ch_cnt_d   = '0;
         samp_cnt_d = '0;
      end else if (wr_valid) begin
         if (ch_cnt_q == LAST_CH) begin
            ch_cnt_d   = '0;
            samp_cnt_d = samp_cnt_q + 1'b1;
         end else begin
            ch_cnt_d = ch_cnt_q + 1'b1;
         end
      end

      if (accept) begin
         wr_bank_d     = ~wr_bank_q;
         frame_ready_d = 1'b1;
         frame_irq_d   = 1'b1;
      end else if (frame_ack) begin
         frame_ready_d = 1'b0;
      end

      if (discard && overflow_q != 8'hFF) begin
         overflow_d = overflow_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ch_cnt_q      <= '0;
         samp_cnt_q    <= '0;
         wr_bank_q     <= 1'b0;
         frame_ready_q <= 1'b0;
         frame_irq_q   <= 1'b0;
         overflow_q    <= '0;
         rd_en_q       <= 1'b0;
      end else begin
         ch_cnt_q      <= ch_cnt_d;
         samp_cnt_q    <= samp_cnt_d;
         wr_bank_q     <= wr_bank_d;
         frame_ready_q <= frame_ready_d;
         frame_irq_q   <= frame_irq_d;
         overflow_q    <= overflow_d;
         rd_en_q       <= rd_en_d;
      end
   end

   // RAM has no reset; the registered rd_en gates the output to zero instead.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[{wr_bank_q, ch_cnt_q, samp_cnt_q}] <= wr_data;
      end
      if (rd_en) begin
         ram_q <= mem[{~wr_bank_q, rd_adr}];
      end
   end

   assign rd_data        = rd_en_q ? ram_q : '0;
   assign frame_ready    = frame_ready_q;
   assign frame_irq      = frame_irq_q;
   assign rd_bank        = ~wr_bank_q;
   assign overflow_count = overflow_q;

endmodule

// File: tb/tb_mic_array_frame_buffer.sv
// Self-checking bench for mic_array_frame_buffer: directed frame scenarios plus
// randomized traffic compared against a frame-level reference model.
module tb_mic_array_frame_buffer;

   localparam int NCH = 8;
   localparam int DW  = 16;
   localparam int FAW = 4;
   localparam int CAW = 3;
   localparam int FS  = 16;
   localparam int FW  = NCH * FS;

   logic           clk = 1'b0;
   logic           rst;
   logic           enable;
   logic           wr_valid;
   logic [DW-1:0]  wr_data;
   logic           rd_en;
   logic [CAW+FAW-1:0] rd_adr;
   logic [DW-1:0]  rd_data;
   logic           frame_ack;
   logic           frame_ready;
   logic           frame_irq;
   logic           rd_bank;
   logic [7:0]     overflow_count;

   mic_array_frame_buffer #(
      .NUM_CHANNELS(NCH),
      .DATA_WIDTH(DW),
      .FRAME_ADDR_WIDTH(FAW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .enable(enable),
      .wr_valid(wr_valid),
      .wr_data(wr_data),
      .rd_en(rd_en),
      .rd_adr(rd_adr),
      .rd_data(rd_data),
      .frame_ack(frame_ack),
      .frame_ready(frame_ready),
      .frame_irq(frame_irq),
      .rd_bank(rd_bank),
      .overflow_count(overflow_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int dut_irq_cnt = 0;

   // Reference model: frame-level state plus an image of both banks.
   bit            m_wr_bank;
   bit            m_ready;
   int            m_ovf;
   int            m_idx;
   logic [DW-1:0] m_mem [0:2*FW-1];
   bit            m_vld [0:2*FW-1];

   typedef struct {
      logic [2:0]  ch;
      logic [3:0]  samp;
      logic [15:0] exp_data;
   } rd_vec_t;

   rd_vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_wr_bank = 1'b0;
      m_ready   = 1'b0;
      m_ovf     = 0;
      m_idx     = 0;
   endtask

   function automatic logic [6:0] adr_of(input int ch, input int samp);
      logic [6:0] a;
      a = 7'(ch * FS + samp);
      return a;
   endfunction

   // One clock: drive inputs, advance the model, then compare after the edge.
   task automatic cyc(input bit en, input bit v, input logic [15:0] d,
                      input bit re, input logic [6:0] adr, input bit ack);
      int            ra;
      int            wa;
      bit            acc;
      bit            chk_rd;
      logic [15:0]   e_rd;
      enable    = en;
      wr_valid  = v;
      wr_data   = d;
      rd_en     = re;
      rd_adr    = adr;
      frame_ack = ack;
      ra     = (m_wr_bank ? 0 : FW) + int'(adr);
      chk_rd = !re || m_vld[ra];
      e_rd   = re ? m_mem[ra] : 16'h0000;
      acc    = 1'b0;
      if (!en) begin
         m_idx = 0;
      end else if (v) begin
         wa = (m_wr_bank ? FW : 0) + (m_idx % NCH) * FS + (m_idx / NCH);
         m_mem[wa] = d;
         m_vld[wa] = 1'b1;
         if (m_idx == FW - 1) begin
            m_idx = 0;
            if (!m_ready || ack) begin
               acc       = 1'b1;
               m_wr_bank = !m_wr_bank;
               m_ready   = 1'b1;
            end else if (m_ovf < 255) begin
               m_ovf++;
            end
         end else begin
            m_idx++;
         end
      end
      if (ack && !acc) m_ready = 1'b0;
      @(posedge clk);
      #1;
      chk("frame_irq", 32'(frame_irq), 32'(acc));
      chk("frame_ready", 32'(frame_ready), 32'(m_ready));
      chk("rd_bank", 32'(rd_bank), 32'(!m_wr_bank));
      chk("overflow_count", 32'(overflow_count), 32'(m_ovf));
      if (chk_rd) chk("rd_data", 32'(rd_data), 32'(e_rd));
      if (frame_irq) dut_irq_cnt++;
   endtask

   task automatic fill(input logic [15:0] base, input bit re_last,
                       input logic [6:0] adr_last, input bit ack_last);
      logic [7:0] s8;
      logic [7:0] c8;
      for (int i = 0; i < FW; i++) begin
         s8 = 8'(i / NCH);
         c8 = 8'(i % NCH);
         cyc(1'b1, 1'b1, base | {s8, c8}, re_last && (i == FW - 1), adr_last,
             ack_last && (i == FW - 1));
      end
   endtask

   task automatic rd1(input int ch, input int samp);
      cyc(1'b1, 1'b0, 16'h0, 1'b1, adr_of(ch, samp), 1'b0);
   endtask

   task automatic ack1();
      cyc(1'b1, 1'b0, 16'h0, 1'b0, 7'h0, 1'b1);
   endtask

   initial begin
      #900us;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int irq0;
      logic [7:0] s8;
      logic [7:0] c8;

      vecs[0] = '{3'd3, 4'd5,  16'h0503};
      vecs[1] = '{3'd0, 4'd0,  16'h0000};
      vecs[2] = '{3'd7, 4'd15, 16'h0F07};
      vecs[3] = '{3'd1, 4'd0,  16'h0001};
      vecs[4] = '{3'd0, 4'd1,  16'h0100};
      vecs[5] = '{3'd6, 4'd9,  16'h0906};

      // Reset
      rst = 1'b1; enable = 1'b0; wr_valid = 1'b0; wr_data = '0;
      rd_en = 1'b0; rd_adr = '0; frame_ack = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_rd_data", 32'(rd_data), 32'h0);
      chk("reset_ready", 32'(frame_ready), 32'h0);
      chk("reset_irq", 32'(frame_irq), 32'h0);
      chk("reset_rd_bank", 32'(rd_bank), 32'h1);
      chk("reset_ovf", 32'(overflow_count), 32'h0);
      rst = 1'b0;
      $display("reset done");

      // Fill frame 1 and read it back
      fill(16'h0000, 1'b0, 7'h0, 1'b0);
      chk("f1_irq_count", 32'(dut_irq_cnt), 32'd1);
      chk("f1_ready", 32'(frame_ready), 32'h1);
      chk("f1_rd_bank", 32'(rd_bank), 32'h0);
      $display("frame 1 filled irq_count=%0d rd_bank=%0d", dut_irq_cnt, rd_bank);
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, 1'b0, 16'h0, 1'b1, {vecs[i].ch, vecs[i].samp}, 1'b0);
         chk("table_rd", 32'(rd_data), 32'(vecs[i].exp_data));
         $display("read ch=%0d samp=%0d data=%04h", vecs[i].ch, vecs[i].samp, rd_data);
      end
      for (int a = 0; a < FW; a++) cyc(1'b1, 1'b0, 16'h0, 1'b1, 7'(a), 1'b0);
      chk("f1_irq_once", 32'(dut_irq_cnt), 32'd1);

      // Ping-pong with a read landing on the swap cycle
      ack1();
      chk("ack_clears_ready", 32'(frame_ready), 32'h0);
      fill(16'h8000, 1'b1, adr_of(3, 5), 1'b0);
      chk("swap_cycle_rd", 32'(rd_data), 32'h0503);
      rd1(3, 5);
      chk("post_swap_rd", 32'(rd_data), 32'h8503);
      chk("f2_rd_bank", 32'(rd_bank), 32'h1);
      $display("ping-pong rd_bank=%0d data=%04h", rd_bank, rd_data);

      // Overflow: three frames without ack
      ack1();
      irq0 = dut_irq_cnt;
      fill(16'h1000, 1'b0, 7'h0, 1'b0);
      fill(16'h2000, 1'b0, 7'h0, 1'b0);
      fill(16'h3000, 1'b0, 7'h0, 1'b0);
      chk("ovf_irq_delta", 32'(dut_irq_cnt - irq0), 32'd1);
      chk("ovf_count2", 32'(overflow_count), 32'd2);
      rd1(3, 5);
      chk("ovf_bank_holds_first", 32'(rd_data), 32'h1503);
      ack1();
      fill(16'h4000, 1'b0, 7'h0, 1'b0);
      chk("ovf_then_swap_bank", 32'(rd_bank), 32'h1);
      rd1(3, 5);
      chk("ovf_then_swap_rd", 32'(rd_data), 32'h4503);
      $display("overflow ovf=%0d rd_bank=%0d", overflow_count, rd_bank);

      // Ack coinciding with completion
      irq0 = dut_irq_cnt;
      fill(16'h5000, 1'b0, 7'h0, 1'b1);
      chk("simul_irq", 32'(dut_irq_cnt - irq0), 32'd1);
      chk("simul_ready", 32'(frame_ready), 32'h1);
      chk("simul_ovf", 32'(overflow_count), 32'd2);
      chk("simul_rd_bank", 32'(rd_bank), 32'h0);
      $display("simultaneous ack ready=%0d ovf=%0d", frame_ready, overflow_count);

      // Enable drop abandons a partial frame
      ack1();
      for (int i = 0; i < 50; i++) cyc(1'b1, 1'b1, 16'h6000 | 16'(i), 1'b0, 7'h0, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 16'h6FFF, 1'b0, 7'h0, 1'b0);
      irq0 = dut_irq_cnt;
      for (int i = 0; i < FW; i++) begin
         s8 = 8'(i / NCH);
         c8 = 8'(i % NCH);
         cyc(1'b1, 1'b1, 16'h7000 | {s8, c8}, 1'b0, 7'h0, 1'b0);
         if (i == 77) chk("no_irq_at_78", 32'(dut_irq_cnt - irq0), 32'd0);
      end
      chk("irq_at_128", 32'(dut_irq_cnt - irq0), 32'd1);
      rd1(3, 5);
      chk("enable_frame_rd", 32'(rd_data), 32'h7503);
      $display("enable test irq_delta=%0d", dut_irq_cnt - irq0);

      // Asynchronous reset mid-frame
      for (int i = 0; i < 40; i++) cyc(1'b1, 1'b1, 16'h9000 | 16'(i), 1'b1, adr_of(3, 5), 1'b0);
      #2;
      wr_valid = 1'b0;
      rd_en    = 1'b0;
      rst      = 1'b1;
      #1;
      chk("arst_rd_data", 32'(rd_data), 32'h0);
      chk("arst_ready", 32'(frame_ready), 32'h0);
      chk("arst_irq", 32'(frame_irq), 32'h0);
      chk("arst_ovf", 32'(overflow_count), 32'h0);
      chk("arst_rd_bank", 32'(rd_bank), 32'h1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      fill(16'hA000, 1'b0, 7'h0, 1'b0);
      chk("post_rst_rd_bank", 32'(rd_bank), 32'h0);
      rd1(3, 5);
      chk("post_rst_rd", 32'(rd_data), 32'hA503);
      $display("mid-frame reset recovered rd_bank=%0d", rd_bank);

      // Randomized traffic against the model
      for (int n = 0; n < 4000; n++) begin
         cyc($urandom_range(0, 999) != 0, $urandom_range(0, 3) != 0, 16'($urandom),
             1'($urandom_range(0, 1)), 7'($urandom), $urandom_range(0, 149) == 0);
      end
      $display("random phase done irq_count=%0d ovf=%0d", dut_irq_cnt, overflow_count);

      // Saturation
      ack1();
      fill(16'h0000, 1'b0, 7'h0, 1'b0);
      for (int f = 0; f < 300; f++) fill(16'(f), 1'b0, 7'h0, 1'b0);
      chk("ovf_saturated", 32'(overflow_count), 32'd255);
      rd1(7, 15);
      cyc(1'b1, 1'b0, 16'h0, 1'b0, adr_of(7, 15), 1'b0);
      chk("rd_en_low_zero", 32'(rd_data), 32'h0);
      $display("saturation ovf=%0d", overflow_count);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mic_array_frame_buffer.md
# mic_array_frame_buffer

Multi-channel, double-banked (ping-pong) frame buffer for the microphone array datapath. It sits between the decimation filter and the Wishbone read logic. It accepts a channel-interleaved sample stream and fills one bank of NUM_CHANNELS x FRAME_SAMPLES words while the host reads the other bank. It swaps banks on frame completion, signals frame-ready and interrupt, and counts frames dropped when the host has not acknowledged in time.

## Interface
Parameters:
- NUM_CHANNELS, 8, microphone channels per sample time; 1..2^CH_ADDR_WIDTH
- DATA_WIDTH, 16, sample width
- FRAME_ADDR_WIDTH, 7, log2 of samples per channel per frame (FRAME_SAMPLES = 2^FRAME_ADDR_WIDTH)
- CH_ADDR_WIDTH (localparam), clog2(NUM_CHANNELS), minimum 1

Ports (one clock; reset is asynchronous and active-high):
- clk, in, 1, single clock for all logic and the RAM
- rst, in, 1, asynchronous active-high reset
- enable, in, 1, capture enable; low holds write counters at zero
- wr_valid, in, 1, wr_data holds the next sample in channel order 0..NUM_CHANNELS-1
- wr_data, in, DATA_WIDTH, sample
- rd_en, in, 1, read enable
- rd_adr, in, CH_ADDR_WIDTH+FRAME_ADDR_WIDTH, read address {channel, sample_index} within the read bank
- rd_data, out, DATA_WIDTH, registered read data
- frame_ack, in, 1, host has finished reading the current read bank
- frame_ready, out, 1, read bank holds an unacknowledged complete frame
- frame_irq, out, 1, one-cycle pulse per accepted frame
- rd_bank, out, 1, bank currently exposed for reading
- overflow_count, out, 8, saturating count of discarded frames

## Operation
- RAM holds 2 x 2^CH_ADDR_WIDTH x FRAME_SAMPLES words. The physical address is {bank, channel, sample_index}.
- Write side uses two counters: ch_cnt (0..NUM_CHANNELS-1) and samp_cnt (0..FRAME_SAMPLES-1).
- Each wr_valid with enable high writes wr_data to {wr_bank, ch_cnt, samp_cnt}, then advances ch_cnt.
  - When ch_cnt wraps past NUM_CHANNELS-1, samp_cnt advances.
  - Channel slots at or above NUM_CHANNELS are never written.
- Frame completion is the write with ch_cnt=NUM_CHANNELS-1 and samp_cnt=FRAME_SAMPLES-1. Both counters then return to 0.
  - Accepted if frame_ready is 0, or frame_ack is high in the same cycle: wr_bank toggles, rd_bank becomes the just-filled bank, frame_ready is set to 1, frame_irq pulses.
  - Discarded if frame_ready is 1 and frame_ack is low: no bank swap, and the next frame overwrites the same write bank. overflow_count increments and saturates at 255.
- frame_ack clears frame_ready when no accepted completion occurs in the same cycle. Ack while frame_ready=0 has no effect.
- rd_bank always equals ~wr_bank.
- enable low:
  - ch_cnt and samp_cnt are cleared synchronously and wr_valid is ignored.
  - frame_ready, the banks, and overflow_count are unaffected.
  - A partial frame is abandoned.
- Read side:
  - rd_data <= RAM[{rd_bank, rd_adr}] when rd_en=1; otherwise rd_data <= 0.
  - Reads are allowed regardless of frame_ready.
- Reset clears counters, frame_ready, frame_irq, rd_data, and overflow_count; wr_bank=0 and rd_bank=1. RAM contents are not initialised.

## Timing
- Write: sample is in the RAM after the wr_valid edge and readable two cycles later, once the bank has swapped.
- Read latency is 1 cycle: rd_adr/rd_en sampled at edge N, rd_data valid after edge N.
- A read in the same cycle as a bank swap uses the pre-swap rd_bank. A read issued the cycle after uses the new bank.
- On the completion edge, frame_ready, rd_bank and frame_irq change together. frame_irq is high for exactly one cycle.
- frame_ack sampled at edge N clears frame_ready after edge N.
- Back-to-back wr_valid on every cycle is supported with no stall. There is no backpressure; data loss is reported only via overflow_count.
- Reset asserted mid-frame: all registers take reset values immediately (asynchronous). After release, capture restarts at channel 0, sample 0 of bank 0.

## Test plan
Bench parameters: NUM_CHANNELS=8, FRAME_ADDR_WIDTH=4, DATA_WIDTH=16.
- Fill frame: write 128 samples with value {samp[7:0], ch[7:0]}, then read all 128 addresses.
  - Required: frame_irq pulses once, frame_ready=1, rd_bank=0.
  - Required: rd_data at {ch=3, samp=5} = 0x0503 one cycle after the address.
- Ping-pong: ack the first frame, then fill a second frame with value +0x8000.
  - Required: rd_bank=1 and reads return the second-frame data.
  - Required: a read issued during the swap cycle returns first-frame data.
- Overflow: fill three frames without ack.
  - Required: one frame_irq and overflow_count=2.
  - Required: the read bank still holds frame 1.
  - Required: after ack, the next completion swaps.
- Simultaneous: assert frame_ack on the completion cycle of frame 2.
  - Required: frame accepted, frame_ready stays 1, overflow_count unchanged.
- Enable/reset: drop enable after 50 samples, then re-enable and write 128 samples.
  - Required: completion occurs at write 128, not 78.
  - Assert rst mid-frame. Required: all outputs 0 immediately, rd_bank=1.
- Saturation and rd_en: force 300 discards. Required: overflow_count=255.
  - Read with rd_en=0. Required: rd_data=0x0000.
